// File: rtl/ef_pwm32_pkg.sv
// Shared types and default widths for the EF_PWM32 compare ramp sequencer.
package ef_pwm32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RAMP     = 2'd1,
    ST_PEND_SET = 2'd2
  } state_e;

  localparam int DEF_W  = 32;
  localparam int DEF_IW = 16;

endpackage

// File: rtl/ef_pwm32_evt_div.sv
// Period-event divider: emits one tick on every Nth period_evt while enabled.
// An interval of 0 behaves as 1 so a ramp can never stall.
module ef_pwm32_evt_div
  import ef_pwm32_pkg::*;
#(
  parameter int IW = DEF_IW
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          evt,
  input  logic          en,
  input  logic          clr,
  input  logic [IW-1:0] interval,
  output logic          tick
);

  logic [IW-1:0] cnt_q;
  logic [IW-1:0] last;

  // Terminal count: interval-1, with interval 0 mapped onto a terminal of 0.
  always_comb begin
    last = '0;
    if (interval != '0) begin
      last = interval - IW'(1);
    end
  end

  // A clear in the same cycle suppresses the tick so a discarded update cannot leak out.
  assign tick = en & evt & ~clr & (cnt_q == last);

  // Period counter, restarted on clear and wrapped at the terminal count.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && evt) begin
      if (cnt_q == last) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + IW'(1);
      end
    end
  end

endmodule

// File: rtl/ef_pwm32_ramp_seq.sv
// Duty-cycle ramp sequencer for one EF_PWM32 compare channel.
// cmp_out only moves on a period boundary so the PWM core never sees a torn compare.
//
//  state       | meaning
//  ------------+---------------------------------------------------------------
//  ST_IDLE     | holding cmp_out, accepting start / set_req
//  ST_RAMP     | stepping cmp_out toward target on every Nth period_evt
//  ST_PEND_SET | waiting for the next period_evt to load target directly
module ef_pwm32_ramp_seq
  import ef_pwm32_pkg::*;
#(
  parameter int            W        = DEF_W,
  parameter int            IW       = DEF_IW,
  parameter logic [W-1:0]  INIT_CMP = '0
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          period_evt,
  input  logic          start,
  input  logic          abort,
  input  logic          set_req,
  input  logic [W-1:0]  target,
  input  logic [W-1:0]  step,
  input  logic [IW-1:0] interval,
  output logic [W-1:0]  cmp_out,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [W-1:0]  cmp_q, cmp_d;
  logic [W-1:0]  target_q, step_q;
  logic [IW-1:0] interval_q;
  logic          done_q, done_d;
  logic          ld_start, ld_set, div_clr;
  logic          tick;
  logic [W-1:0]  upd;
  logic [W:0]    diff_up, diff_dn, step_ext;

  ef_pwm32_evt_div #(.IW(IW)) u_div (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .evt      (period_evt),
    .en       (state_q == ST_RAMP),
    .clr      (div_clr),
    .interval (interval_q),
    .tick     (tick)
  );

  // Next compare value for one ramp step; the distance is taken in W+1 bits so
  // the step is clamped at target instead of overshooting or wrapping.
  always_comb begin
    diff_up  = {1'b0, target_q} - {1'b0, cmp_q};
    diff_dn  = {1'b0, cmp_q} - {1'b0, target_q};
    step_ext = {1'b0, step_q};
    upd      = target_q;
    if (target_q >= cmp_q) begin
      if (step_q != '0 && diff_up > step_ext) begin
        upd = cmp_q + step_q;
      end
    end else begin
      if (step_q != '0 && diff_dn > step_ext) begin
        upd = cmp_q - step_q;
      end
    end
  end

  // Next-state, compare and done decode; abort outranks any update due that cycle.
  always_comb begin
    state_d  = state_q;
    cmp_d    = cmp_q;
    done_d   = 1'b0;
    ld_start = 1'b0;
    ld_set   = 1'b0;
    div_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (target == cmp_q) begin
            done_d = 1'b1;
          end else begin
            ld_start = 1'b1;
            div_clr  = 1'b1;
            state_d  = ST_RAMP;
          end
        end else if (set_req) begin
          ld_set  = 1'b1;
          state_d = ST_PEND_SET;
        end
      end
      ST_RAMP: begin
        if (abort) begin
          div_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (tick) begin
          cmp_d = upd;
          if (upd == target_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_PEND_SET: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (period_evt) begin
          cmp_d   = target_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, compare output and done pulse registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cmp_q   <= INIT_CMP;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmp_q   <= cmp_d;
      done_q  <= done_d;
    end
  end

  // Ramp parameters are captured only when a request is accepted from idle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      target_q   <= '0;
      step_q     <= '0;
      interval_q <= '0;
    end else if (ld_start) begin
      target_q   <= target;
      step_q     <= step;
      interval_q <= interval;
    end else if (ld_set) begin
      target_q   <= target;
    end
  end

  assign cmp_out = cmp_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_ef_pwm32_ramp_seq.sv
// Directed bench for the EF_PWM32 compare ramp sequencer.
module tb_ef_pwm32_ramp_seq;

  logic        HCLK;
  logic        HRESETn;
  logic        period_evt;
  logic        start;
  logic        abort;
  logic        set_req;
  logic [31:0] target;
  logic [31:0] step;
  logic [15:0] interval;
  logic [31:0] cmp_out;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  ef_pwm32_ramp_seq #(.W(32), .IW(16), .INIT_CMP(32'd0)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .period_evt (period_evt),
    .start      (start),
    .abort      (abort),
    .set_req    (set_req),
    .target     (target),
    .step       (step),
    .interval   (interval),
    .cmp_out    (cmp_out),
    .busy       (busy),
    .done       (done)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Stimulus drivers: entered and left on a falling edge.
  task automatic do_start(input logic [31:0] t, input logic [31:0] s, input logic [15:0] i);
    start = 1'b1; target = t; step = s; interval = i;
    @(negedge HCLK);
    start = 1'b0;
  endtask

  task automatic do_set(input logic [31:0] t);
    set_req = 1'b1; target = t;
    @(negedge HCLK);
    set_req = 1'b0;
  endtask

  task automatic do_evt();
    period_evt = 1'b1;
    @(negedge HCLK);
    period_evt = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge HCLK);
    abort = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic test_reset();
    checks++; if (cmp_out !== 32'd0) begin failures++; $display("FAIL reset_cmp actual=%0d required=0", cmp_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done actual=%b required=0", done); end
  endtask

  task automatic test_up_ramp();
    logic [31:0] exp_cmp [4];
    logic        exp_done [4];
    exp_cmp  = '{32'd30, 32'd60, 32'd90, 32'd100};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_start(32'd100, 32'd30, 16'd1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL up_busy actual=%b required=1", busy); end
    for (int k = 0; k < 4; k++) begin
      do_evt();
      checks++; if (cmp_out !== exp_cmp[k]) begin failures++; $display("FAIL up_cmp[%0d] actual=%0d required=%0d", k, cmp_out, exp_cmp[k]); end
      checks++; if (done !== exp_done[k]) begin failures++; $display("FAIL up_done[%0d] actual=%b required=%b", k, done, exp_done[k]); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL up_end_busy actual=%b required=0", busy); end
  endtask

  task automatic test_down_ramp();
    logic [31:0] exp_cmp [6];
    logic        exp_done [6];
    exp_cmp  = '{32'd100, 32'd60, 32'd60, 32'd20, 32'd20, 32'd10};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_start(32'd10, 32'd40, 16'd2);
    for (int k = 0; k < 6; k++) begin
      do_evt();
      checks++; if (cmp_out !== exp_cmp[k]) begin failures++; $display("FAIL down_cmp[%0d] actual=%0d required=%0d", k, cmp_out, exp_cmp[k]); end
      checks++; if (done !== exp_done[k]) begin failures++; $display("FAIL down_done[%0d] actual=%b required=%b", k, done, exp_done[k]); end
    end
  endtask

  task automatic test_boundary();
    do_set(32'hFFFF_FFFB);
    do_evt();
    checks++; if (cmp_out !== 32'hFFFF_FFFB) begin failures++; $display("FAIL bnd_preset actual=%h required=fffffffb", cmp_out); end
    do_start(32'hFFFF_FFFF, 32'd100, 16'd1);
    do_evt();
    checks++; if (cmp_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL bnd_top actual=%h required=ffffffff", cmp_out); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL bnd_top_done actual=%b required=1", done); end
    do_start(32'd5, 32'd0, 16'd3);
    do_evt();
    do_evt();
    checks++; if (cmp_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL bnd_step0_wait actual=%h required=ffffffff", cmp_out); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bnd_step0_busy actual=%b required=1", busy); end
    do_evt();
    checks++; if (cmp_out !== 32'd5) begin failures++; $display("FAIL bnd_step0_jump actual=%h required=5", cmp_out); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL bnd_step0_done actual=%b required=1", done); end
    do_start(32'd0, 32'd100, 16'd0);
    do_evt();
    checks++; if (cmp_out !== 32'd0) begin failures++; $display("FAIL bnd_bottom actual=%h required=0", cmp_out); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL bnd_bottom_done actual=%b required=1", done); end
  endtask

  task automatic test_abort();
    do_start(32'd100, 32'd30, 16'd1);
    do_evt();
    do_evt();
    checks++; if (cmp_out !== 32'd60) begin failures++; $display("FAIL abort_pre actual=%0d required=60", cmp_out); end
    do_abort();
    checks++; if (cmp_out !== 32'd60) begin failures++; $display("FAIL abort_hold actual=%0d required=60", cmp_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy actual=%b required=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done actual=%b required=0", done); end
    repeat (3) do_evt();
    checks++; if (cmp_out !== 32'd60) begin failures++; $display("FAIL abort_idle_evts actual=%0d required=60", cmp_out); end
    do_start(32'd100, 32'd30, 16'd1);
    abort = 1'b1; period_evt = 1'b1;
    @(negedge HCLK);
    abort = 1'b0; period_evt = 1'b0;
    checks++; if (cmp_out !== 32'd60) begin failures++; $display("FAIL abort_with_evt actual=%0d required=60", cmp_out); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_with_evt_flags actual=%b%b required=00", busy, done); end
  endtask

  task automatic test_pend_set();
    do_set(32'd500);
    idle_cycles(10);
    checks++; if (cmp_out !== 32'd60) begin failures++; $display("FAIL pend_hold actual=%0d required=60", cmp_out); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pend_busy actual=%b required=1", busy); end
    do_start(32'd999, 32'd1, 16'd1);
    do_evt();
    checks++; if (cmp_out !== 32'd500) begin failures++; $display("FAIL pend_load actual=%0d required=500", cmp_out); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL pend_done actual=%b required=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pend_end_busy actual=%b required=0", busy); end
    idle_cycles(1);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL pend_done_pulse actual=%b required=0", done); end
  endtask

  task automatic test_mid_reset();
    do_start(32'd1000, 32'd100, 16'd1);
    do_evt();
    checks++; if (cmp_out !== 32'd600) begin failures++; $display("FAIL mrst_pre actual=%0d required=600", cmp_out); end
    #2 HRESETn = 1'b0;
    #1;
    checks++; if (cmp_out !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL mrst_state actual=cmp %0d busy %b done %b required=cmp 0 busy 0 done 0", cmp_out, busy, done);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    do_start(32'd0, 32'd10, 16'd1);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL mrst_eq_done actual=%b required=1", done); end
    checks++; if (busy !== 1'b0 || cmp_out !== 32'd0) begin failures++; $display("FAIL mrst_eq_state actual=busy %b cmp %0d required=busy 0 cmp 0", busy, cmp_out); end
    idle_cycles(1);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mrst_eq_pulse actual=%b required=0", done); end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; set_req = 1'b1; target = 32'd50; step = 32'd20; interval = 16'd1;
    @(negedge HCLK);
    start = 1'b0; set_req = 1'b0;
    do_evt();
    checks++; if (cmp_out !== 32'd20) begin failures++; $display("FAIL b2b_start_wins actual=%0d required=20", cmp_out); end
    do_evt();
    do_evt();
    checks++; if (cmp_out !== 32'd50 || done !== 1'b1) begin failures++; $display("FAIL b2b_end actual=cmp %0d done %b required=cmp 50 done 1", cmp_out, done); end
  endtask

  initial begin
    HRESETn = 1'b0; period_evt = 1'b0; start = 1'b0; abort = 1'b0; set_req = 1'b0;
    target = '0; step = '0; interval = '0;
    idle_cycles(2);
    test_reset();
    HRESETn = 1'b1;
    @(negedge HCLK);
    test_reset();
    test_up_ramp();
    test_down_ramp();
    test_boundary();
    test_abort();
    test_pend_set();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
